// File: rtl/serial_adder_acc.sv
// Bit-serial adder: accepts a, b, cin, adds LSB-first one bit per clock, result valid WIDTH edges after accept.
// Backpressure: result (sum/cout) held in DONE until out_ready; no new operand accepted until back in IDLE.
module serial_adder_acc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             step_s;
  logic             step_c;

  always_comb begin
    step_s = a_sr[0] ^ b_sr[0] ^ carry;
    step_c = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      cout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr     <= a;
            b_sr     <= b;
            carry    <= cin;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH steps.
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= {step_s, sum_sr[WIDTH-1:1]};
          carry  <= step_c;
          if (cnt == LAST_STEP) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            cout      <= step_c;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign sum = sum_sr;

endmodule

// File: tb/tb_serial_adder_acc.sv
// Directed and random checks of serial_adder_acc at WIDTH=8.
module tb_serial_adder_acc;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       busy;

  int n_tests;
  int n_fail;
  int n_accepts;
  int n_results;
  logic ov_prev;

  serial_adder_acc #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts rising edges of out_valid, one per delivered result.
  always @(negedge clk) begin
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) n_results++;
      ov_prev = out_valid;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        input logic [7:0] es, input logic ec, input int stall,
                        input bit noise, input string tag);
    int lat;
    @(negedge clk);
    lat = 0;
    while (!in_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    a = ta;
    b = tb_v;
    cin = tc;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n_accepts++;
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (lat == 1) check({tag, ".busy_run"}, {30'd0, busy, in_ready}, 32'd2);
      if (noise && lat == 2) begin
        a = ~ta;
        b = tb_v ^ 8'h5a;
        cin = ~tc;
        in_valid = 1'b1;
      end
      if (noise && lat == 3) in_valid = 1'b0;
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'd8);
    check({tag, ".sum"}, 32'(sum), 32'(es));
    check({tag, ".cout"}, 32'(cout), 32'(ec));
    check({tag, ".done_flags"}, {29'd0, busy, in_ready, out_valid}, 32'd1);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, ".stall"}, {22'd0, in_ready, out_valid, cout, sum}, {22'd0, 1'b0, 1'b1, ec, es});
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, ".release"}, {22'd0, in_ready, out_valid, cout, sum}, {22'd0, 1'b1, 1'b0, ec, es});
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;
    logic [8:0] full;
    n_tests = 0;
    n_fail = 0;
    n_accepts = 0;
    n_results = 0;
    ov_prev = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 8'h00;
    b = 8'h00;
    cin = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
    check("reset_result", {23'd0, cout, sum}, 32'd0);
    rst = 1'b0;

    run_op(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 0, 1'b0, "t1_basic");
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0, 1'b0, "t2_ripple");
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, 1'b0, "t2_allones");
    run_op(8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 5, 1'b0, "t3_stall");
    run_op(8'h21, 8'h42, 1'b0, 8'h63, 1'b0, 0, 1'b1, "t4_noise");
    run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 0, 1'b0, "t_zero");
    run_op(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 0, 1'b0, "t5_pre");

    // Abort an operation on its third RUN edge.
    @(negedge clk);
    a = 8'hFF;
    b = 8'h00;
    cin = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_midrun_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_reset_flags", {29'd0, in_ready, out_valid, busy}, 32'd4);
    check("t5_reset_result", {23'd0, cout, sum}, 32'd0);
    repeat (10) @(negedge clk);
    check("t5_no_result", {30'd0, out_valid, in_ready}, 32'd1);
    run_op(8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 2, 1'b0, "t5_after");

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
      run_op(ra, rb, rc, full[7:0], full[8], int'($urandom_range(0, 3)), 1'b0, "t6_rand");
    end

    @(negedge clk);
    check("results_per_accept", 32'(n_results), 32'(n_accepts));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
